// File: rtl/mips_timer_slave.sv
// Memory-mapped countdown timer (CTRL/PRESET/COUNT) with interrupt request to CP0.
// Latency: register reads are combinational from addr; writes take effect on the next rising edge.
// Backpressure: none. The bus is always accepted with no wait states.
//
// Ports:
//   clk    - system clock, all state updates on rising edge
//   reset  - synchronous active-high reset, clears all state
//   addr   - word select: 00 CTRL, 01 PRESET, 10 COUNT (read-only), 11 unused (reads 0)
//   we     - write strobe
//   wdata  - write data
//   rdata  - read data for the selected word
//   irq    - interrupt request (flag & IM)
module mips_timer_slave #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   addr,
  input  logic         we,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         irq
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_t;

  localparam logic [W-1:0] ONE = W'(1);

  state_t       state, state_nxt;
  logic [3:0]   ctrl, ctrl_nxt;      // {IM, MODE[1:0], EN}
  logic [W-1:0] preset, preset_nxt;
  logic [W-1:0] count, count_nxt;
  logic         flag, flag_nxt;
  // Marks a flag raised by an auto-reload expiry, which only lives one cycle.
  logic         pulse, pulse_nxt;

  logic         en;
  logic [1:0]   mode;
  logic         im;
  logic         ctrl_wr;
  logic         preset_wr;

  assign en        = ctrl[0];
  assign mode      = ctrl[2:1];
  assign im        = ctrl[3];
  assign ctrl_wr   = we && (addr == 2'b00);
  assign preset_wr = we && (addr == 2'b01);

  always_comb begin
    state_nxt  = state;
    ctrl_nxt   = ctrl;
    preset_nxt = preset;
    count_nxt  = count;
    flag_nxt   = flag;
    pulse_nxt  = 1'b0;

    if (pulse) begin
      flag_nxt = 1'b0;
    end

    case (state)
      IDLE: begin
        if (en) begin
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        count_nxt = preset;
        state_nxt = CNT;
      end
      CNT: begin
        if (!en) begin
          state_nxt = IDLE;
        end else if (count > ONE) begin
          count_nxt = count - ONE;
        end else begin
          // Expiring from 1, or from 0 when PRESET was 0; never wraps.
          count_nxt = '0;
          state_nxt = INT;
        end
      end
      INT: begin
        state_nxt = IDLE;
        flag_nxt  = 1'b1;
        if (mode == 2'b01) begin
          // Auto-reload: EN stays set, so IDLE reloads on the next edge.
          pulse_nxt = 1'b1;
        end else begin
          ctrl_nxt[0] = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (preset_wr) begin
      preset_nxt = wdata;
    end

    // A CPU write to CTRL overrides the FSM's own EN clear in the same cycle.
    // Enabling also acknowledges any pending flag.
    if (ctrl_wr) begin
      ctrl_nxt = wdata[3:0];
      if (wdata[0]) begin
        flag_nxt  = 1'b0;
        pulse_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      ctrl   <= '0;
      preset <= '0;
      count  <= '0;
      flag   <= 1'b0;
      pulse  <= 1'b0;
    end else begin
      state  <= state_nxt;
      ctrl   <= ctrl_nxt;
      preset <= preset_nxt;
      count  <= count_nxt;
      flag   <= flag_nxt;
      pulse  <= pulse_nxt;
    end
  end

  always_comb begin
    rdata = '0;
    case (addr)
      2'b00:   rdata = {{(W-4){1'b0}}, ctrl};
      2'b01:   rdata = preset;
      2'b10:   rdata = count;
      default: rdata = '0;
    endcase
  end

  // Masking hides the request but leaves the flag pending.
  assign irq = flag & im;

endmodule

// File: tb/tb_mips_timer_slave.sv
// Self-checking bench for mips_timer_slave: scheduled COUNT/irq expectations
// are queued per clock edge and checked on the falling edge; register reads
// are checked directly shortly after the rising edge.
module tb_mips_timer_slave;

  logic        clk;
  logic        reset;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  mips_timer_slave #(.W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n++;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int          e;
    bit          is_irq;
    logic [31:0] val;
  } sb_t;

  sb_t sb[$];
  sb_t cur;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  // Expected value of COUNT (is_irq=0) or irq (is_irq=1) after rising edge e.
  task automatic push(input int e, input bit is_irq, input logic [31:0] v);
    sb_t x;
    int  i;
    x.e = e;
    x.is_irq = is_irq;
    x.val = v;
    i = 0;
    while (i < sb.size() && sb[i].e <= e) i++;
    sb.insert(i, x);
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].e <= edge_n) begin
      cur = sb.pop_front();
      if (cur.e != edge_n) check("sb_late", edge_n, cur.e);
      else if (cur.is_irq) check("irq", {31'b0, irq}, cur.val);
      else check("count", rdata, cur.val);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int e);
    while (edge_n < e) tick();
  endtask

  // Write lands on the next rising edge; e returns that edge number.
  task automatic wr(input logic [1:0] a, input logic [31:0] d, output int e);
    @(negedge clk);
    #1;
    addr = a;
    wdata = d;
    we = 1'b1;
    @(posedge clk);
    #1;
    e = edge_n;
    we = 1'b0;
    addr = 2'b10;
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(tag, rdata, exp);
    addr = 2'b10;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() > 0 && k < 200) begin
      tick();
      k++;
    end
    if (sb.size() > 0) begin
      check("sb_drain", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int e0, e1, e;
    reset = 1'b1;
    we    = 1'b0;
    addr  = 2'b10;
    wdata = '0;
    repeat (2) tick();
    reset = 1'b0;

    // Reset state
    rd_chk("rst_ctrl", 2'b00, 32'h0);
    rd_chk("rst_preset", 2'b01, 32'h0);
    rd_chk("rst_count", 2'b10, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);

    // One-shot, PRESET=5, CTRL=0x9
    wr(2'b01, 32'd5, e);
    rd_chk("preset_rb", 2'b01, 32'd5);
    wr(2'b00, 32'h9, e0);
    for (int k = 2; k <= 7; k++) push(e0 + k, 1'b0, 32'(7 - k));
    for (int k = 1; k <= 12; k++) push(e0 + k, 1'b1, (k >= 8) ? 32'd1 : 32'd0);
    wait_until(e0 + 12);
    rd_chk("oneshot_ctrl", 2'b00, 32'h8);
    wr(2'b00, 32'h9, e1);
    push(e1, 1'b1, 32'd0);
    push(e1 + 2, 1'b0, 32'd5);
    push(e1 + 7, 1'b0, 32'd0);
    push(e1 + 7, 1'b1, 32'd0);
    push(e1 + 8, 1'b1, 32'd1);
    drain();
    do_reset();

    // Auto-reload, PRESET=3, CTRL=0xB
    wr(2'b01, 32'd3, e);
    wr(2'b00, 32'hB, e0);
    for (int k = 1; k <= 20; k++)
      push(e0 + k, 1'b1, (k == 6 || k == 12 || k == 18) ? 32'd1 : 32'd0);
    for (int k = 2; k <= 19; k++) begin
      int j;
      j = (k - 2) % 6;
      push(e0 + k, 1'b0, (j < 3) ? 32'(3 - j) : 32'd0);
    end
    drain();
    do_reset();

    // Mask: PRESET=2, CTRL=0x1, then CTRL=0x8
    wr(2'b01, 32'd2, e);
    wr(2'b00, 32'h1, e0);
    for (int k = 1; k <= 8; k++) push(e0 + k, 1'b1, 32'd0);
    wait_until(e0 + 8);
    rd_chk("mask_ctrl", 2'b00, 32'h0);
    wr(2'b00, 32'h8, e1);
    push(e1, 1'b1, 32'd1);
    push(e1 + 1, 1'b1, 32'd1);
    drain();
    do_reset();

    // Pause/restart: PRESET=10, clear EN as COUNT reaches 6
    wr(2'b01, 32'd10, e);
    wr(2'b00, 32'h1, e0);
    for (int k = 2; k <= 6; k++) push(e0 + k, 1'b0, 32'(12 - k));
    for (int k = 7; k <= 10; k++) push(e0 + k, 1'b0, 32'd6);
    wait_until(e0 + 5);
    wr(2'b00, 32'h0, e);
    wait_until(e0 + 7);
    wr(2'b10, 32'h1234, e);
    rd_chk("unused_rd", 2'b11, 32'h0);
    wait_until(e0 + 10);
    wr(2'b00, 32'h1, e1);
    push(e1, 1'b0, 32'd6);
    push(e1 + 1, 1'b0, 32'd6);
    push(e1 + 2, 1'b0, 32'd10);
    push(e1 + 3, 1'b0, 32'd9);
    push(e1 + 4, 1'b0, 32'd8);
    push(e1 + 5, 1'b0, 32'd7);
    wait_until(e1 + 3);
    wr(2'b01, 32'd4, e);
    drain();
    rd_chk("preset_mid", 2'b01, 32'd4);
    do_reset();

    // CTRL all-ones with PRESET=0: mode 11 acts as one-shot
    wr(2'b11, 32'hFFFF_FFFF, e);
    wr(2'b00, 32'hFFFF_FFFF, e0);
    rd_chk("ctrl_mask", 2'b00, 32'hF);
    push(e0 + 2, 1'b0, 32'd0);
    for (int k = 1; k <= 5; k++) push(e0 + k, 1'b1, (k >= 4) ? 32'd1 : 32'd0);
    drain();
    rd_chk("ctrl_m3_en", 2'b00, 32'hE);
    do_reset();

    // Reset mid-count, mode 1
    wr(2'b01, 32'd5, e);
    wr(2'b00, 32'hB, e0);
    push(e0 + 2, 1'b0, 32'd5);
    wait_until(e0 + 2);
    push(e0 + 3, 1'b0, 32'd0);
    for (int k = 3; k <= 24; k++) push(e0 + k, 1'b1, 32'd0);
    do_reset();
    rd_chk("mid_rst_ctrl", 2'b00, 32'h0);
    rd_chk("mid_rst_preset", 2'b01, 32'h0);
    rd_chk("mid_rst_count", 2'b10, 32'h0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got edge %0d expected finish", edge_n);
    $fatal(1);
  end

endmodule
